// File: rtl/ps2_pkg.sv
// Shared constants and enumerations for the PS/2 keyboard command sequencer.
package ps2_pkg;

  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_SET_LED  = 8'hED;

  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;
  localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
  localparam logic [7:0] RSP_BAT_FAIL = 8'hFC;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_SENT,
    ST_WAIT_ACK,
    ST_WAIT_BAT,
    ST_FAIL,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE       = 2'd0,
    ERR_TX_TIMEOUT = 2'd1,
    ERR_NO_ACK     = 2'd2,
    ERR_BAT        = 2'd3
  } err_code_t;

endpackage

// File: rtl/ps2_us_timer.sv
// Loadable down-counter; tc is high once the count has reached zero and stays there.
module ps2_us_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              count <= '0;
    else if (load)           count <= load_value;
    else if (count != '0)    count <= count - 1'b1;
  end

  assign tc = (count == '0);

endmodule

// File: rtl/ps2_command_sequencer.sv
// Sequences reset/BAT and set-LEDs command transactions over the PS/2 host-to-device path.
//   state        | meaning
//   ST_IDLE      | no transaction; pick init (priority) or LED request
//   ST_SEND      | the_command valid, send_command low until transmitter flags clear
//   ST_WAIT_SENT | send_command high, waiting for done or transmit timeout
//   ST_WAIT_ACK  | waiting for FA/FE with ack timer running
//   ST_WAIT_BAT  | waiting for AA/FC with BAT timer running
//   ST_FAIL      | latch error and error_code
//   ST_DONE      | transaction complete, led_applied pulse for LED transactions
module ps2_command_sequencer
  import ps2_pkg::*;
#(
  parameter int CLOCK          = 100,
  parameter int ACK_TIMEOUT_US = 20000,
  parameter int BAT_TIMEOUT_US = 1000000,
  parameter int MAX_RETRIES    = 3,
  parameter bit AUTO_INIT      = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       init_req,
  input  logic       led_req,
  input  logic [2:0] led_state,
  output logic [7:0] the_command,
  output logic       send_command,
  input  logic       command_was_sent,
  input  logic       error_communication_timed_out,
  input  logic [7:0] received_data,
  input  logic       received_data_en,
  output logic       busy,
  output logic       kb_ready,
  output logic       led_applied,
  output logic       error,
  output logic [1:0] error_code
);

  localparam int TW = ($clog2(CLOCK*BAT_TIMEOUT_US) < 1) ? 1 : $clog2(CLOCK*BAT_TIMEOUT_US);
  localparam int RW = ($clog2(MAX_RETRIES+1) < 1) ? 1 : $clog2(MAX_RETRIES+1);
  localparam logic [TW-1:0] ACK_LOAD  = TW'(CLOCK*ACK_TIMEOUT_US - 1);
  localparam logic [TW-1:0] BAT_LOAD  = TW'(CLOCK*BAT_TIMEOUT_US - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

  state_t          state, state_nxt;
  err_code_t       fail_code, fail_code_nxt, err_q;
  logic            init_pending, led_pending;
  logic [2:0]      led_req_state, led_txn;
  logic            txn_led, second_byte;
  logic [RW-1:0]   retry_cnt;
  logic            sel_init, sel_led, retry_evt, do_retry, ack_ok, bat_ok;
  logic            timer_load, timer_tc;
  logic [TW-1:0]   timer_value;

  always_comb begin
    state_nxt     = state;
    fail_code_nxt = fail_code;
    sel_init      = 1'b0;
    sel_led       = 1'b0;
    retry_evt     = 1'b0;
    do_retry      = 1'b0;
    ack_ok        = 1'b0;
    bat_ok        = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (init_pending) begin
          sel_init  = 1'b1;
          state_nxt = ST_SEND;
        end else if (led_pending) begin
          sel_led   = 1'b1;
          state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        if (!command_was_sent && !error_communication_timed_out) state_nxt = ST_WAIT_SENT;
      end
      ST_WAIT_SENT: begin
        if (command_was_sent)                   state_nxt = ST_WAIT_ACK;
        else if (error_communication_timed_out) retry_evt = 1'b1;
      end
      ST_WAIT_ACK: begin
        // A reply byte wins over a simultaneous timer expiry.
        if (received_data_en) begin
          if (received_data == RSP_ACK) begin
            ack_ok = 1'b1;
            if (txn_led && !second_byte) state_nxt = ST_SEND;
            else if (txn_led)            state_nxt = ST_DONE;
            else                         state_nxt = ST_WAIT_BAT;
          end else if (received_data == RSP_RESEND) begin
            retry_evt = 1'b1;
          end
        end else if (timer_tc) begin
          retry_evt = 1'b1;
        end
      end
      ST_WAIT_BAT: begin
        if (received_data_en && received_data == RSP_BAT_OK) begin
          bat_ok    = 1'b1;
          state_nxt = ST_DONE;
        end else if ((received_data_en && received_data == RSP_BAT_FAIL) ||
                     (!received_data_en && timer_tc)) begin
          fail_code_nxt = ERR_BAT;
          state_nxt     = ST_FAIL;
        end
      end
      ST_FAIL: state_nxt = ST_IDLE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase

    if (retry_evt) begin
      if (retry_cnt == RETRY_MAX) begin
        fail_code_nxt = (state == ST_WAIT_SENT) ? ERR_TX_TIMEOUT : ERR_NO_ACK;
        state_nxt     = ST_FAIL;
      end else begin
        do_retry  = 1'b1;
        state_nxt = ST_SEND;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      fail_code     <= ERR_NONE;
      err_q         <= ERR_NONE;
      init_pending  <= AUTO_INIT;
      led_pending   <= 1'b0;
      led_req_state <= 3'b000;
      led_txn       <= 3'b000;
      txn_led       <= 1'b0;
      second_byte   <= 1'b0;
      retry_cnt     <= '0;
      the_command   <= 8'h00;
      error         <= 1'b0;
      kb_ready      <= 1'b0;
    end else begin
      state     <= state_nxt;
      fail_code <= fail_code_nxt;

      // A new request in the cycle its flag is consumed stays queued.
      if (init_req)      init_pending <= 1'b1;
      else if (sel_init) init_pending <= 1'b0;
      if (led_req) begin
        led_pending   <= 1'b1;
        led_req_state <= led_state;
      end else if (sel_led) begin
        led_pending   <= 1'b0;
      end

      if (sel_init || sel_led) begin
        txn_led     <= sel_led;
        led_txn     <= led_req_state;
        second_byte <= 1'b0;
        retry_cnt   <= '0;
        error       <= 1'b0;
        err_q       <= ERR_NONE;
        the_command <= sel_init ? CMD_RESET : CMD_SET_LED;
      end
      if (sel_init) kb_ready <= 1'b0;

      if (do_retry) retry_cnt <= retry_cnt + 1'b1;
      if (ack_ok) begin
        retry_cnt <= '0;
        if (txn_led && !second_byte) begin
          second_byte <= 1'b1;
          the_command <= {5'b00000, led_txn};
        end
      end
      if (bat_ok) kb_ready <= 1'b1;

      if (state == ST_FAIL) begin
        error <= 1'b1;
        err_q <= fail_code;
        if (!txn_led) kb_ready <= 1'b0;
      end
    end
  end

  assign timer_load  = (state_nxt != state);
  assign timer_value = (state_nxt == ST_WAIT_BAT) ? BAT_LOAD : ACK_LOAD;

  ps2_us_timer #(.WIDTH(TW)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_value),
    .tc         (timer_tc)
  );

  assign send_command = (state == ST_WAIT_SENT);
  assign busy         = (state != ST_IDLE);
  assign led_applied  = (state == ST_DONE) && txn_led;
  assign error_code   = err_q;

endmodule

// File: tb/tb_ps2_command_sequencer.sv
// Randomized bench: transmitter/keyboard models plus a transaction-level expectation model.
module tb_ps2_command_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       init_req = 1'b0;
  logic       led_req = 1'b0;
  logic [2:0] led_state = 3'b000;
  logic [7:0] the_command;
  logic       send_command;
  logic       command_was_sent = 1'b0;
  logic       error_communication_timed_out = 1'b0;
  logic [7:0] received_data = 8'h00;
  logic       received_data_en = 1'b0;
  logic       busy, kb_ready, led_applied, error;
  logic [1:0] error_code;

  ps2_command_sequencer #(
    .CLOCK(1), .ACK_TIMEOUT_US(50), .BAT_TIMEOUT_US(200), .MAX_RETRIES(3), .AUTO_INIT(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .init_req(init_req), .led_req(led_req), .led_state(led_state),
    .the_command(the_command), .send_command(send_command),
    .command_was_sent(command_was_sent),
    .error_communication_timed_out(error_communication_timed_out),
    .received_data(received_data), .received_data_en(received_data_en),
    .busy(busy), .kb_ready(kb_ready), .led_applied(led_applied),
    .error(error), .error_code(error_code)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int led_pulses = 0;
  int pulses_base = 0;
  int stable_err = 0;
  bit tx_fail = 1'b0;
  int tx_delay = 0;
  logic [7:0] sent_q[$];
  int         sent_t[$];
  logic [7:0] done_q[$];
  int         script[$];   // replies per successful send; -1 means stay silent
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (led_applied) led_pulses <= led_pulses + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Host-to-device transmitter: completes (or times out) a few cycles after send_command rises.
  initial begin : tx_model
    logic [7:0] cmd;
    int n;
    forever begin
      @(posedge clk); #1;
      if (send_command === 1'b1) begin
        cmd = the_command;
        sent_q.push_back(cmd);
        sent_t.push_back(cyc);
        n = (tx_delay > 0) ? tx_delay : int'($urandom_range(1, 4));
        repeat (n) begin
          @(posedge clk); #1;
          if (send_command && the_command !== cmd) stable_err++;
        end
        if (send_command) begin
          if (tx_fail) error_communication_timed_out = 1'b1;
          else begin
            command_was_sent = 1'b1;
            done_q.push_back(cmd);
          end
        end
        n = 0;
        while (send_command === 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        command_was_sent = 1'b0;
        error_communication_timed_out = 1'b0;
      end
    end
  end

  task automatic strobe(input logic [7:0] b);
    received_data = b;
    received_data_en = 1'b1;
    @(posedge clk); #1;
    received_data_en = 1'b0;
    received_data = 8'h00;
  endtask

  task automatic reply(input int r);
    if ($urandom_range(0, 2) == 0) strobe(8'($urandom_range(0, 127)));
    repeat ($urandom_range(1, 6)) begin @(posedge clk); #1; end
    if (r >= 0) strobe(8'(r));
  endtask

  // Keyboard: answers each delivered byte from the script, defaulting to FA (and AA after reset).
  initial begin : kbd_model
    logic [7:0] cmd;
    int r;
    forever begin
      @(posedge clk); #1;
      if (done_q.size() > 0) begin
        cmd = done_q.pop_front();
        r = (script.size() > 0) ? script.pop_front() : 'hFA;
        reply(r);
        if (cmd == 8'hFF && r == 'hFA) begin
          r = (script.size() > 0) ? script.pop_front() : 'hAA;
          reply(r);
        end
      end
    end
  end

  task automatic clear_logs();
    sent_q.delete();
    sent_t.delete();
    done_q.delete();
    script.delete();
    exp_q.delete();
    pulses_base = led_pulses;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    int idle_run = 0;
    repeat (2) begin @(posedge clk); #1; end
    while (idle_run < 3 && n < 4000) begin
      @(posedge clk); #1;
      n++;
      idle_run = busy ? 0 : idle_run + 1;
    end
    chk({tag, " idle_within_budget"}, 32'(idle_run >= 3), 1);
    repeat (8) begin @(posedge clk); #1; end
  endtask

  task automatic check_sends(input string tag);
    chk({tag, " n_sends"}, sent_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < sent_q.size(); i++)
      chk($sformatf("%s byte%0d", tag, i), sent_q[i], exp_q[i]);
  endtask

  task automatic pulse_led(input logic [2:0] v);
    @(posedge clk); #1;
    led_req = 1'b1;
    led_state = v;
    @(posedge clk); #1;
    led_req = 1'b0;
  endtask

  task automatic pulse_init();
    @(posedge clk); #1;
    init_req = 1'b1;
    @(posedge clk); #1;
    init_req = 1'b0;
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    logic [2:0] v;
    logic [7:0] bv;
    int k[2];
    bit failed;
    int n;
    int gap;

    #23;
    chk("reset_outputs", {the_command, send_command, busy, kb_ready, led_applied, error, error_code}, 0);
    @(posedge clk); #1;
    reset = 1'b1;

    // auto-init after reset release
    wait_idle("t1");
    exp_q.push_back(8'hFF);
    check_sends("t1");
    chk("t1 kb_ready", kb_ready, 1);
    chk("t1 error", error, 0);
    chk("t1 busy", busy, 0);

    clear_logs();
    pulse_led(3'b101);
    wait_idle("t2");
    exp_q.push_back(8'hED); exp_q.push_back(8'h05);
    check_sends("t2");
    chk("t2 led_pulses", led_pulses - pulses_base, 1);
    chk("t2 error", error, 0);

    clear_logs();
    script.push_back('hFE); script.push_back('hFA);
    pulse_led(3'b011);
    wait_idle("t3");
    exp_q.push_back(8'hED); exp_q.push_back(8'hED); exp_q.push_back(8'h03);
    check_sends("t3");
    chk("t3 error", error, 0);
    chk("t3 led_pulses", led_pulses - pulses_base, 1);

    clear_logs();
    tx_fail = 1'b1;
    pulse_led(3'b001);
    wait_idle("t4");
    repeat (4) exp_q.push_back(8'hED);
    repeat (30) begin @(posedge clk); #1; end
    check_sends("t4");
    chk("t4 error", error, 1);
    chk("t4 error_code", error_code, 1);
    chk("t4 send_command", send_command, 0);
    chk("t4 busy", busy, 0);
    chk("t4 kb_ready", kb_ready, 1);
    chk("t4 led_pulses", led_pulses - pulses_base, 0);
    tx_fail = 1'b0;

    // simultaneous init+led, then a newer led request while busy
    clear_logs();
    @(posedge clk); #1;
    init_req = 1'b1; led_req = 1'b1; led_state = 3'b111;
    @(posedge clk); #1;
    init_req = 1'b0; led_req = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    pulse_led(3'b010);
    wait_idle("t5");
    exp_q.push_back(8'hFF); exp_q.push_back(8'hED); exp_q.push_back(8'h02);
    check_sends("t5");
    chk("t5 kb_ready", kb_ready, 1);
    chk("t5 error", error, 0);
    chk("t5 led_pulses", led_pulses - pulses_base, 1);

    clear_logs();
    script.push_back('hFA); script.push_back('hFC);
    pulse_init();
    wait_idle("t6");
    exp_q.push_back(8'hFF);
    check_sends("t6");
    chk("t6 error", error, 1);
    chk("t6 error_code", error_code, 3);
    chk("t6 kb_ready", kb_ready, 0);

    // silent keyboard: four ack timeouts on FF
    clear_logs();
    tx_delay = 2;
    repeat (4) script.push_back(-1);
    pulse_init();
    wait_idle("t7");
    repeat (4) exp_q.push_back(8'hFF);
    check_sends("t7");
    chk("t7 error_code", error_code, 2);
    chk("t7 kb_ready", kb_ready, 0);
    for (int i = 1; i < sent_t.size(); i++) begin
      gap = sent_t[i] - sent_t[i-1];
      chk($sformatf("t7 gap%0d=%0d in 53..55", i, gap), 32'(gap >= 53 && gap <= 55), 1);
    end
    tx_delay = 0;

    // randomized set-LEDs transactions with random resend/silence runs per byte
    for (int it = 0; it < 8; it++) begin
      clear_logs();
      v = 3'($urandom_range(0, 7));
      for (int b = 0; b < 2; b++) k[b] = ($urandom_range(0, 3) == 0) ? 4 : int'($urandom_range(0, 2));
      failed = 1'b0;
      for (int b = 0; b < 2 && !failed; b++) begin
        bv = (b == 0) ? 8'hED : {5'b00000, v};
        for (int a = 0; a < k[b]; a++) begin
          exp_q.push_back(bv);
          script.push_back(($urandom_range(0, 1) == 0) ? 'hFE : -1);
        end
        if (k[b] >= 4) failed = 1'b1;
        else begin
          exp_q.push_back(bv);
          script.push_back('hFA);
        end
      end
      pulse_led(v);
      wait_idle($sformatf("r%0d", it));
      check_sends($sformatf("r%0d", it));
      chk($sformatf("r%0d error", it), error, 32'(failed));
      chk($sformatf("r%0d error_code", it), error_code, failed ? 2 : 0);
      chk($sformatf("r%0d led_pulses", it), led_pulses - pulses_base, failed ? 0 : 1);
    end

    // asynchronous reset while waiting for an ACK
    clear_logs();
    script.push_back(-1);
    pulse_init();
    n = 0;
    while (!send_command && n < 100) begin @(posedge clk); #1; n++; end
    n = 0;
    while (send_command && n < 100) begin @(posedge clk); #1; n++; end
    repeat (5) begin @(posedge clk); #1; end
    chk("t8 busy_before_reset", busy, 1);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk("t8 async_reset_outputs",
        {the_command, send_command, busy, kb_ready, led_applied, error, error_code}, 0);
    repeat (3) begin @(posedge clk); #1; end
    clear_logs();
    reset = 1'b1;
    wait_idle("t8");
    exp_q.push_back(8'hFF);
    check_sends("t8");
    chk("t8 kb_ready", kb_ready, 1);
    chk("t8 error", error, 0);

    chk("cmd_stable_while_sending", stable_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
